// File: rtl/mux_stream_nto1_pkg.sv
// Shared constants and helpers for the N-to-1 registered stream multiplexer.
package mux_stream_nto1_pkg;

    localparam int MODE_SELECT = 0;
    localparam int MODE_RR     = 1;

    // ceil(log2(n)), never less than 1 so a select port always has a bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_stream_nto1_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward with wrap and
// returns the one-hot grant, its index and the pointer to use next cycle.
module mux_stream_nto1_rr_arbiter
    import mux_stream_nto1_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_ptr,
    input  logic             i_advance,
    output logic [N-1:0]     o_grant,
    output logic [SEL_W-1:0] o_idx,
    output logic [SEL_W-1:0] o_ptr_nxt
);

    logic             w_found;
    logic [SEL_W-1:0] w_c;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_c     = '0;
        for (int k = 1; k <= N; k++) begin
            w_c = SEL_W'((32'(i_ptr) + 32'(k)) % 32'(N));
            if (!w_found && i_req[w_c]) begin
                w_found    = 1'b1;
                o_grant[w_c] = 1'b1;
                o_idx      = w_c;
            end
        end
    end

    assign o_ptr_nxt = i_advance ? o_idx : i_ptr;

endmodule

// File: rtl/mux_stream_nto1.sv
// N-input registered stream mux with valid/ready on every channel; grant is
// either Sel-driven or round-robin, and the output is a single pipeline stage.
module mux_stream_nto1
    import mux_stream_nto1_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    parameter  int MODE   = MODE_SELECT,
    localparam int SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [NUM_IN*WIDTH-1:0] InData,
    input  logic [NUM_IN-1:0]       InValid,
    output logic [NUM_IN-1:0]       InReady,
    input  logic [SEL_W-1:0]        Sel,
    output logic [WIDTH-1:0]        OutData,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [SEL_W-1:0]        OutSrc,
    output logic                    SelErr,
    output logic [15:0]             XferCount
);

    logic              w_load;
    logic              w_any;
    logic              w_accept;
    logic              w_sel_bad;
    logic [NUM_IN-1:0] w_grant;
    logic [SEL_W-1:0]  w_idx;
    logic [WIDTH-1:0]  w_data;

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_src;
    logic              r_sel_err;
    logic [15:0]       r_xfer_cnt;

    assign w_load    = !r_out_valid || OutReady;
    assign w_any     = |w_grant;
    assign w_accept  = w_load && w_any;
    assign w_sel_bad = (MODE == MODE_SELECT) && (32'(Sel) >= 32'(NUM_IN));

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] r_ptr;
            logic [SEL_W-1:0] w_ptr_nxt;

            mux_stream_nto1_rr_arbiter #(.N(NUM_IN)) u_arb (
                .i_req     (InValid),
                .i_ptr     (r_ptr),
                .i_advance (w_accept),
                .o_grant   (w_grant),
                .o_idx     (w_idx),
                .o_ptr_nxt (w_ptr_nxt)
            );

            // Starting at NUM_IN-1 makes channel 0 the first in line after reset.
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) r_ptr <= SEL_W'(NUM_IN - 1);
                else          r_ptr <= w_ptr_nxt;
            end
        end else begin : g_sel
            always_comb begin
                w_grant = '0;
                for (int i = 0; i < NUM_IN; i++) begin
                    w_grant[i] = (Sel == SEL_W'(i)) && InValid[i];
                end
            end
            assign w_idx = Sel;
        end
    endgenerate

    // AND-OR select keeps an out-of-range Sel from ever indexing past InData.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant[i]) w_data = w_data | InData[i*WIDTH +: WIDTH];
        end
    end

    assign InReady = w_load ? w_grant : '0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_sel_err   <= 1'b0;
            r_xfer_cnt  <= '0;
        end else begin
            if (w_load) r_out_valid <= w_any;
            if (w_accept) begin
                r_out_data <= w_data;
                r_out_src  <= w_idx;
            end
            if (w_sel_bad && |InValid) r_sel_err <= 1'b1;
            if (r_out_valid && OutReady) r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign OutData   = r_out_data;
    assign OutValid  = r_out_valid;
    assign OutSrc    = r_out_src;
    assign SelErr    = r_sel_err;
    assign XferCount = r_xfer_cnt;

endmodule

// File: tb/tb_mux_stream_nto1.sv
// Directed bench for mux_stream_nto1: select mode (4 and 3 inputs) and
// round-robin mode side by side, sharing clock and reset.
module tb_mux_stream_nto1;

    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    logic [127:0] a_data;  logic [3:0] a_vld, a_rdy; logic [1:0] a_sel, a_src;
    logic [31:0]  a_odata; logic a_ovld, a_ordy, a_serr; logic [15:0] a_cnt;
    logic [95:0]  b_data;  logic [2:0] b_vld, b_rdy; logic [1:0] b_sel, b_src;
    logic [31:0]  b_odata; logic b_ovld, b_ordy, b_serr; logic [15:0] b_cnt;
    logic [127:0] c_data;  logic [3:0] c_vld, c_rdy; logic [1:0] c_sel, c_src;
    logic [31:0]  c_odata; logic c_ovld, c_ordy, c_serr; logic [15:0] c_cnt;

    mux_stream_nto1 #(.WIDTH(32), .NUM_IN(4), .MODE(0)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .InData(a_data), .InValid(a_vld), .InReady(a_rdy),
        .Sel(a_sel), .OutData(a_odata), .OutValid(a_ovld), .OutReady(a_ordy),
        .OutSrc(a_src), .SelErr(a_serr), .XferCount(a_cnt));

    mux_stream_nto1 #(.WIDTH(32), .NUM_IN(3), .MODE(0)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .InData(b_data), .InValid(b_vld), .InReady(b_rdy),
        .Sel(b_sel), .OutData(b_odata), .OutValid(b_ovld), .OutReady(b_ordy),
        .OutSrc(b_src), .SelErr(b_serr), .XferCount(b_cnt));

    mux_stream_nto1 #(.WIDTH(32), .NUM_IN(4), .MODE(1)) dut_c (
        .Clk(Clk), .Reset_n(Reset_n), .InData(c_data), .InValid(c_vld), .InReady(c_rdy),
        .Sel(c_sel), .OutData(c_odata), .OutValid(c_ovld), .OutReady(c_ordy),
        .OutSrc(c_src), .SelErr(c_serr), .XferCount(c_cnt));

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    int rr1[6] = '{0, 1, 2, 3, 0, 1};
    int rr2[4] = '{3, 0, 3, 0};

    initial begin
        a_data = '0; a_vld = '0; a_sel = '0; a_ordy = 1'b1;
        b_data = '0; b_vld = '0; b_sel = '0; b_ordy = 1'b1;
        c_data = '0; c_vld = '0; c_sel = '0; c_ordy = 1'b1;
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_ovld", 32'(a_ovld), 32'd0);
        chk("rst_odata", a_odata, 32'd0);
        chk("rst_src", 32'(a_src), 32'd0);
        chk("rst_serr", 32'(a_serr), 32'd0);
        chk("rst_cnt", 32'(a_cnt), 32'd0);
        Reset_n = 1'b1;

        // select mode, single beat from channel 2
        a_sel = 2'd2; a_data = {32'h3, 32'hDEADBEEF, 32'h1, 32'h0}; a_vld = 4'b0100;
        #1 chk("a_inrdy", 32'(a_rdy), 32'h4);
        tick;
        chk("a_ovld", 32'(a_ovld), 32'd1);
        chk("a_odata", a_odata, 32'hDEADBEEF);
        chk("a_src", 32'(a_src), 32'd2);
        a_vld = '0;
        tick;
        chk("a_bubble_vld", 32'(a_ovld), 32'd0);
        chk("a_bubble_data", a_odata, 32'hDEADBEEF);
        chk("a_cnt1", 32'(a_cnt), 32'd1);

        // backpressure: held beat survives Sel/InData churn
        a_sel = 2'd0; a_data[31:0] = 32'h11; a_vld = 4'b0001;
        tick;
        chk("bp_load", a_odata, 32'h11);
        a_ordy = 1'b0; a_vld = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            a_sel  = 2'(k);
            a_data = {4{32'(k) + 32'hA0}};
            #1 chk("bp_inrdy", 32'(a_rdy), 32'd0);
            tick;
            chk("bp_data", a_odata, 32'h11);
            chk("bp_vld", 32'(a_ovld), 32'd1);
        end
        a_ordy = 1'b1; a_sel = 2'd3; a_data[127:96] = 32'h33; a_vld = 4'b1000;
        #1 chk("bp_release_rdy", 32'(a_rdy), 32'h8);
        tick;
        chk("bp_next_data", a_odata, 32'h33);
        chk("bp_next_src", 32'(a_src), 32'd3);
        chk("bp_next_vld", 32'(a_ovld), 32'd1);
        chk("bp_cnt", 32'(a_cnt), 32'd2);
        a_vld = '0;
        tick;

        // out-of-range select on a 3-input mux
        b_sel = 2'd0; b_data = {32'h2, 32'h1, 32'h5}; b_vld = 3'b001;
        tick;
        chk("b_load", b_odata, 32'h5);
        b_sel = 2'd3; b_vld = 3'b111;
        #1 chk("b_oor_rdy", 32'(b_rdy), 32'd0);
        chk("b_serr_pre", 32'(b_serr), 32'd0);
        tick;
        chk("b_oor_vld", 32'(b_ovld), 32'd0);
        chk("b_serr", 32'(b_serr), 32'd1);
        chk("b_hold_data", b_odata, 32'h5);
        b_sel = 2'd0; b_vld = '0;
        tick;
        chk("b_serr_sticky", 32'(b_serr), 32'd1);
        tick;
        chk("b_serr_sticky2", 32'(b_serr), 32'd1);

        // round robin
        c_data = {32'hC3, 32'hC2, 32'hC1, 32'hC0}; c_vld = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("rr_src", 32'(c_src), 32'(rr1[k]));
            chk("rr_data", c_odata, 32'hC0 + 32'(rr1[k]));
        end
        c_vld = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("rr_alt_src", 32'(c_src), 32'(rr2[k]));
        end
        c_vld = 4'b0100;
        tick;
        chk("rr_pre_rst_src", 32'(c_src), 32'd2);
        chk("rr_pre_rst_cnt", 32'(c_cnt), 32'd10);

        // reset mid-stream
        Reset_n = 1'b0;
        #1;
        chk("mr_ovld", 32'(c_ovld), 32'd0);
        chk("mr_cnt", 32'(c_cnt), 32'd0);
        chk("mr_serr", 32'(b_serr), 32'd0);
        tick;
        Reset_n = 1'b1; c_vld = 4'b1111;
        #1 chk("mr_rdy", 32'(c_rdy), 32'h1);
        tick;
        chk("mr_first_src", 32'(c_src), 32'd0);
        chk("mr_first_data", c_odata, 32'hC0);
        c_vld = '0;

        // XferCount wrap: 65536 transfers from a fresh counter
        a_sel = 2'd0; a_vld = 4'b0001; a_ordy = 1'b1; a_data[31:0] = 32'h77;
        repeat (65536) tick;
        chk("wrap_ffff", 32'(a_cnt), 32'hFFFF);
        tick;
        chk("wrap_zero", 32'(a_cnt), 32'd0);
        tick;
        chk("wrap_one", 32'(a_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
